// File: rtl/pixel_fetch_ctrl.sv
// pixel_fetch_ctrl: streams one N_PIX-pixel 1-bit image out of block RAM
// to the NN core on a valid/ready stream tagged with index and last flag.
// Ports: clk, rst (async, active-low); start/busy/done image control;
//   mem_en/mem_addr/mem_dout RAM read port (READ_LAT cycle latency);
//   pix_valid/pix_ready/pix_data/pix_idx/pix_last output pixel stream.
module pixel_fetch_ctrl #(
    parameter int N_PIX    = 784,
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1,
    parameter int FIFO_DEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_dout,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic [ADDR_W-1:0] pix_idx,
    output logic              pix_last
);
    // The FIFO is the registered head (pix_*) plus BODY entries behind it.
    localparam int BODY = FIFO_DEP - 1;
    localparam int PW   = (BODY > 1) ? $clog2(BODY) : 1;
    localparam int BW   = $clog2(BODY + 1);
    localparam int CW   = $clog2(FIFO_DEP + READ_LAT + 2);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   issue_cnt;
    logic [READ_LAT-1:0] pv;
    logic [ADDR_W-1:0]   ptag [READ_LAT];
    logic                body_dat [BODY];
    logic [ADDR_W-1:0]   body_idx [BODY];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [BW-1:0]       body_cnt;
    logic [CW-1:0]       occ;
    logic                pop;
    logic                push;
    logic                load;
    logic                b_pop;
    logic                b_push;
    logic                credit;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BODY - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop    = pix_valid & pix_ready;
    assign push   = pv[READ_LAT-1];
    assign load   = ~pix_valid | pop;
    assign b_pop  = load & (body_cnt != '0);
    // An arriving pixel skips the body when the head is being refilled
    // and nothing older is waiting.
    assign b_push = push & ~(load & (body_cnt == '0));

    // Everything issued but not yet popped: current read, reads in the
    // RAM pipeline, and FIFO contents. A pop this cycle frees a slot.
    always_comb begin
        occ = CW'(pix_valid) + CW'(body_cnt) + CW'(mem_en);
        for (int i = 0; i < READ_LAT; i++) begin
            occ = occ + CW'(pv[i]);
        end
        credit = occ < (CW'(FIFO_DEP) + CW'(pop));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            done   <= 1'b0;
            mem_en <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_addr  <= '0;
                        issue_cnt <= (N_PIX > 1) ? ADDR_W'(1) : '0;
                        state     <= (N_PIX > 1) ? S_FETCH : S_DRAIN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (credit) begin
                        mem_en   <= 1'b1;
                        mem_addr <= issue_cnt;
                        if (issue_cnt == LAST) begin
                            state <= S_DRAIN;
                        end else begin
                            issue_cnt <= issue_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && pix_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv        <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            body_cnt  <= '0;
            pix_valid <= 1'b0;
            pix_data  <= 1'b0;
            pix_idx   <= '0;
            pix_last  <= 1'b0;
            for (int i = 0; i < READ_LAT; i++) begin
                ptag[i] <= '0;
            end
            for (int i = 0; i < BODY; i++) begin
                body_dat[i] <= 1'b0;
                body_idx[i] <= '0;
            end
        end else begin
            pv[0]   <= mem_en;
            ptag[0] <= mem_addr;
            for (int i = 1; i < READ_LAT; i++) begin
                pv[i]   <= pv[i-1];
                ptag[i] <= ptag[i-1];
            end
            if (b_push) begin
                body_dat[wr_ptr] <= mem_dout;
                body_idx[wr_ptr] <= ptag[READ_LAT-1];
                wr_ptr           <= nxt(wr_ptr);
            end
            if (b_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({b_push, b_pop})
                2'b10:   body_cnt <= body_cnt + 1'b1;
                2'b01:   body_cnt <= body_cnt - 1'b1;
                default: body_cnt <= body_cnt;
            endcase
            if (load) begin
                if (b_pop) begin
                    pix_valid <= 1'b1;
                    pix_data  <= body_dat[rd_ptr];
                    pix_idx   <= body_idx[rd_ptr];
                    pix_last  <= body_idx[rd_ptr] == LAST;
                end else if (push) begin
                    pix_valid <= 1'b1;
                    pix_data  <= mem_dout;
                    pix_idx   <= ptag[READ_LAT-1];
                    pix_last  <= ptag[READ_LAT-1] == LAST;
                end else begin
                    pix_valid <= 1'b0;
                end
            end
        end
    end
endmodule
